// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register placed right after the register file.
// Captures the decoded instruction and both source operands each cycle and
// hands them to EX one cycle later. A WB->ID bypass covers the register file's
// same-cycle write/read behaviour (it returns the old value), and the stage
// supports stall, flush and a carried branch-prediction bit.
// Optional feature: define LOAD_USE_DETECT_EN to enable in-stage load-use
// detection (ID_stall_out plus an automatic one-cycle bubble). Without it,
// ID_stall_out is tied low and load-use hazards must be handled via stall_in.

module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int XLEN   = 32
) (
   input  logic              clock,
   input  logic              reset_n,

   input  logic              ID_valid,
   input  logic [XLEN-1:0]   ID_pc,
   input  logic              ID_pred_taken,
   input  logic [4:0]        ID_rs1_addr,
   input  logic [4:0]        ID_rs2_addr,
   input  logic [4:0]        ID_rd_addr,
   input  logic [XLEN-1:0]   ID_rs1_data,
   input  logic [XLEN-1:0]   ID_rs2_data,
   input  logic [XLEN-1:0]   ID_imm,
   input  logic [CTRL_W-1:0] ID_ctrl,
   input  logic              ID_reg_wr_enb,
   input  logic              ID_mem_rd,

   input  logic              WB_reg_wr_enb,
   input  logic [4:0]        WB_reg_write_addr,
   input  logic [XLEN-1:0]   WB_reg_write_data,

   input  logic              stall_in,
   input  logic              flush_in,
   output logic              ID_stall_out,

   output logic              EX_valid,
   output logic [XLEN-1:0]   EX_pc,
   output logic              EX_pred_taken,
   output logic [4:0]        EX_rs1_addr,
   output logic [4:0]        EX_rs2_addr,
   output logic [4:0]        EX_rd_addr,
   output logic [XLEN-1:0]   EX_rs1_data,
   output logic [XLEN-1:0]   EX_rs2_data,
   output logic [XLEN-1:0]   EX_imm,
   output logic [CTRL_W-1:0] EX_ctrl,
   output logic              EX_reg_wr_enb,
   output logic              EX_mem_rd
);

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic            bubble;

   // Operand selection: x0 is always zero, otherwise a WB write to the same
   // register this cycle overrides the stale register file value.
   always_comb begin
      rs1_fwd = ID_rs1_data;
      if (ID_rs1_addr == 5'd0)
         rs1_fwd = '0;
      else if (WB_reg_wr_enb && (WB_reg_write_addr == ID_rs1_addr))
         rs1_fwd = WB_reg_write_data;

      rs2_fwd = ID_rs2_data;
      if (ID_rs2_addr == 5'd0)
         rs2_fwd = '0;
      else if (WB_reg_wr_enb && (WB_reg_write_addr == ID_rs2_addr))
         rs2_fwd = WB_reg_write_data;
   end

`ifdef LOAD_USE_DETECT_EN
   // A load in EX whose result is needed by the ID instruction forces one bubble.
   assign bubble = EX_valid && EX_mem_rd && (EX_rd_addr != 5'd0) &&
                   ((EX_rd_addr == ID_rs1_addr) || (EX_rd_addr == ID_rs2_addr)) &&
                   ID_valid && !stall_in && !flush_in;
`else
   assign bubble = 1'b0;
`endif

   assign ID_stall_out = bubble;

   // Pipeline register: flush/bubble clear, stall holds, otherwise capture ID.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         EX_valid      <= 1'b0;
         EX_pc         <= '0;
         EX_pred_taken <= 1'b0;
         EX_rs1_addr   <= '0;
         EX_rs2_addr   <= '0;
         EX_rd_addr    <= '0;
         EX_rs1_data   <= '0;
         EX_rs2_data   <= '0;
         EX_imm        <= '0;
         EX_ctrl       <= '0;
         EX_reg_wr_enb <= 1'b0;
         EX_mem_rd     <= 1'b0;
      end else if (flush_in || bubble) begin
         EX_valid      <= 1'b0;
         EX_pc         <= '0;
         EX_pred_taken <= 1'b0;
         EX_rs1_addr   <= '0;
         EX_rs2_addr   <= '0;
         EX_rd_addr    <= '0;
         EX_rs1_data   <= '0;
         EX_rs2_data   <= '0;
         EX_imm        <= '0;
         EX_ctrl       <= '0;
         EX_reg_wr_enb <= 1'b0;
         EX_mem_rd     <= 1'b0;
      end else if (!stall_in) begin
         EX_valid      <= ID_valid;
         EX_pc         <= ID_pc;
         EX_pred_taken <= ID_pred_taken;
         EX_rs1_addr   <= ID_rs1_addr;
         EX_rs2_addr   <= ID_rs2_addr;
         EX_rd_addr    <= ID_rd_addr;
         EX_rs1_data   <= rs1_fwd;
         EX_rs2_data   <= rs2_fwd;
         EX_imm        <= ID_imm;
         EX_ctrl       <= ID_valid ? ID_ctrl : '0;
         EX_reg_wr_enb <= ID_valid && ID_reg_wr_enb;
         EX_mem_rd     <= ID_valid && ID_mem_rd;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. A driver issues one ID
// instruction per cycle and pushes the expected EX contents into a queue; a
// monitor pops and compares after every rising edge. Expected operands come
// from an architectural register file model kept in the bench.

module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        pred;
      logic [4:0]  rs1a;
      logic [4:0]  rs2a;
      logic [4:0]  rda;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [7:0]  ctrl;
      logic        rwe;
      logic        mrd;
   } ex_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        pred;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [7:0]  ctrl;
      logic        rwe;
      logic        mrd;
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        stall;
      logic        flush;
   } stim_t;

   logic        clock;
   logic        reset_n;
   logic        ID_valid;
   logic [31:0] ID_pc;
   logic        ID_pred_taken;
   logic [4:0]  ID_rs1_addr;
   logic [4:0]  ID_rs2_addr;
   logic [4:0]  ID_rd_addr;
   logic [31:0] ID_rs1_data;
   logic [31:0] ID_rs2_data;
   logic [31:0] ID_imm;
   logic [7:0]  ID_ctrl;
   logic        ID_reg_wr_enb;
   logic        ID_mem_rd;
   logic        WB_reg_wr_enb;
   logic [4:0]  WB_reg_write_addr;
   logic [31:0] WB_reg_write_data;
   logic        stall_in;
   logic        flush_in;
   logic        ID_stall_out;
   logic        EX_valid;
   logic [31:0] EX_pc;
   logic        EX_pred_taken;
   logic [4:0]  EX_rs1_addr;
   logic [4:0]  EX_rs2_addr;
   logic [4:0]  EX_rd_addr;
   logic [31:0] EX_rs1_data;
   logic [31:0] EX_rs2_data;
   logic [31:0] EX_imm;
   logic [7:0]  EX_ctrl;
   logic        EX_reg_wr_enb;
   logic        EX_mem_rd;

   ex_t         exp_q[$];
   ex_t         exm;
   logic [31:0] regs [32];
   int          checks;
   int          passes;

   id_ex_stage #(.CTRL_W(8), .XLEN(32)) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .ID_valid          (ID_valid),
      .ID_pc             (ID_pc),
      .ID_pred_taken     (ID_pred_taken),
      .ID_rs1_addr       (ID_rs1_addr),
      .ID_rs2_addr       (ID_rs2_addr),
      .ID_rd_addr        (ID_rd_addr),
      .ID_rs1_data       (ID_rs1_data),
      .ID_rs2_data       (ID_rs2_data),
      .ID_imm            (ID_imm),
      .ID_ctrl           (ID_ctrl),
      .ID_reg_wr_enb     (ID_reg_wr_enb),
      .ID_mem_rd         (ID_mem_rd),
      .WB_reg_wr_enb     (WB_reg_wr_enb),
      .WB_reg_write_addr (WB_reg_write_addr),
      .WB_reg_write_data (WB_reg_write_data),
      .stall_in          (stall_in),
      .flush_in          (flush_in),
      .ID_stall_out      (ID_stall_out),
      .EX_valid          (EX_valid),
      .EX_pc             (EX_pc),
      .EX_pred_taken     (EX_pred_taken),
      .EX_rs1_addr       (EX_rs1_addr),
      .EX_rs2_addr       (EX_rs2_addr),
      .EX_rd_addr        (EX_rd_addr),
      .EX_rs1_data       (EX_rs1_data),
      .EX_rs2_data       (EX_rs2_data),
      .EX_imm            (EX_imm),
      .EX_ctrl           (EX_ctrl),
      .EX_reg_wr_enb     (EX_reg_wr_enb),
      .EX_mem_rd         (EX_mem_rd)
   );

   // Free-running 10 time-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic ex_t actualEx();
      ex_t a;
      a.valid = EX_valid;
      a.pc    = EX_pc;
      a.pred  = EX_pred_taken;
      a.rs1a  = EX_rs1_addr;
      a.rs2a  = EX_rs2_addr;
      a.rda   = EX_rd_addr;
      a.rs1d  = EX_rs1_data;
      a.rs2d  = EX_rs2_data;
      a.imm   = EX_imm;
      a.ctrl  = EX_ctrl;
      a.rwe   = EX_reg_wr_enb;
      a.mrd   = EX_mem_rd;
      return a;
   endfunction

   task automatic checkOutput(input string name, input ex_t act, input ex_t exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   task automatic checkFlag(input string name, input logic act, input logic exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t randStim();
      stim_t s;
      s.valid   = ($urandom_range(0, 4) != 0);
      s.pc      = $urandom;
      s.pred    = 1'($urandom_range(0, 1));
      s.rs1     = 5'($urandom_range(0, 7));
      s.rs2     = 5'($urandom_range(0, 7));
      s.rd      = 5'($urandom_range(0, 7));
      s.imm     = $urandom;
      s.ctrl    = 8'($urandom_range(0, 255));
      s.rwe     = 1'($urandom_range(0, 1));
      s.mrd     = ($urandom_range(0, 2) == 0);
      s.wb_en   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
         0:       s.wb_addr = s.rs1;
         1:       s.wb_addr = s.rs2;
         default: s.wb_addr = 5'($urandom_range(0, 7));
      endcase
      s.wb_data = $urandom;
      s.stall   = ($urandom_range(0, 4) == 0);
      s.flush   = ($urandom_range(0, 9) == 0);
      return s;
   endfunction

   // One pipeline cycle: drive ID/WB at the falling edge, predict the EX
   // contents after the next rising edge and queue them for the monitor.
   task automatic applyStimulus(input stim_t s);
      logic [31:0] post [32];
      logic        stall_exp;
      ex_t         nxt;
      @(negedge clock);
      ID_valid          = s.valid;
      ID_pc             = s.pc;
      ID_pred_taken     = s.pred;
      ID_rs1_addr       = s.rs1;
      ID_rs2_addr       = s.rs2;
      ID_rd_addr        = s.rd;
      ID_rs1_data       = (s.rs1 == 5'd0) ? $urandom : regs[s.rs1];
      ID_rs2_data       = (s.rs2 == 5'd0) ? $urandom : regs[s.rs2];
      ID_imm            = s.imm;
      ID_ctrl           = s.ctrl;
      ID_reg_wr_enb     = s.rwe;
      ID_mem_rd         = s.mrd;
      WB_reg_wr_enb     = s.wb_en;
      WB_reg_write_addr = s.wb_addr;
      WB_reg_write_data = s.wb_data;
      stall_in          = s.stall;
      flush_in          = s.flush;
      #1;
      // Architectural register state once this cycle's WB write has landed.
      post = regs;
      if (s.wb_en && s.wb_addr != 5'd0) post[s.wb_addr] = s.wb_data;
`ifdef LOAD_USE_DETECT_EN
      stall_exp = exm.valid && exm.mrd && exm.rda != 5'd0 &&
                  (exm.rda == s.rs1 || exm.rda == s.rs2) &&
                  s.valid && !s.stall && !s.flush;
`else
      stall_exp = 1'b0;
`endif
      checkFlag("id_stall_out", ID_stall_out, stall_exp);
      if (s.flush || stall_exp) begin
         nxt = '0;
      end else if (s.stall) begin
         nxt = exm;
      end else begin
         nxt.valid = s.valid;
         nxt.pc    = s.pc;
         nxt.pred  = s.pred;
         nxt.rs1a  = s.rs1;
         nxt.rs2a  = s.rs2;
         nxt.rda   = s.rd;
         nxt.rs1d  = post[s.rs1];
         nxt.rs2d  = post[s.rs2];
         nxt.imm   = s.imm;
         nxt.ctrl  = s.valid ? s.ctrl : 8'd0;
         nxt.rwe   = s.valid & s.rwe;
         nxt.mrd   = s.valid & s.mrd;
      end
      exm = nxt;
      exp_q.push_back(nxt);
      regs = post;
   endtask

   // Monitor: after every rising edge compare EX against the oldest prediction.
   initial begin
      ex_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("ex_regs", actualEx(), e);
         end
      end
   end

   // Asynchronous reset: EX must clear before any clock edge.
   task automatic pulseReset();
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("reset_async_clear", actualEx(), ex_t'(0));
      checkFlag("reset_stall_out", ID_stall_out, 1'b0);
      exp_q.delete();
      exm = '0;
      repeat (2) @(posedge clock);
      #3;
      reset_n = 1'b1;
   endtask

   initial begin
      stim_t s;
      checks = 0;
      passes = 0;
      exm    = '0;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      s = idleStim();
      ID_valid = 0; ID_pc = 0; ID_pred_taken = 0; ID_rs1_addr = 0; ID_rs2_addr = 0;
      ID_rd_addr = 0; ID_rs1_data = 0; ID_rs2_data = 0; ID_imm = 0; ID_ctrl = 0;
      ID_reg_wr_enb = 0; ID_mem_rd = 0; WB_reg_wr_enb = 0; WB_reg_write_addr = 0;
      WB_reg_write_data = 0; stall_in = 0; flush_in = 0;
      reset_n = 1'b0;
      #1;
      checkOutput("reset_state", actualEx(), ex_t'(0));
      repeat (2) @(posedge clock);
      #3;
      reset_n = 1'b1;

      // Preload register values through WB with ID idle.
      s = idleStim(); s.wb_en = 1; s.wb_addr = 5'd3; s.wb_data = 32'h11;   applyStimulus(s);
      s = idleStim(); s.wb_en = 1; s.wb_addr = 5'd4; s.wb_data = 32'h22;   applyStimulus(s);
      s = idleStim(); s.wb_en = 1; s.wb_addr = 5'd5; s.wb_data = 32'hAAAA; applyStimulus(s);

      // Plain load.
      s = idleStim();
      s.valid = 1; s.pc = 32'h100; s.rs1 = 5'd3; s.rs2 = 5'd4; s.rd = 5'd9;
      s.imm = 32'hFFFF_FFF0; s.pred = 1; s.ctrl = 8'h5A; s.rwe = 1;
      applyStimulus(s);

      // WB bypass on rs1, then x0 with a WB write to x0, then rs1==rs2.
      s = idleStim();
      s.valid = 1; s.pc = 32'h104; s.rs1 = 5'd5; s.rs2 = 5'd3; s.rd = 5'd1; s.rwe = 1;
      s.wb_en = 1; s.wb_addr = 5'd5; s.wb_data = 32'h1234;
      applyStimulus(s);
      s = idleStim();
      s.valid = 1; s.pc = 32'h108; s.rs1 = 5'd0; s.rs2 = 5'd0; s.rd = 5'd2; s.rwe = 1;
      s.wb_en = 1; s.wb_addr = 5'd0; s.wb_data = 32'hDEAD;
      applyStimulus(s);
      s = idleStim();
      s.valid = 1; s.pc = 32'h10C; s.rs1 = 5'd6; s.rs2 = 5'd6; s.rd = 5'd2;
      s.wb_en = 1; s.wb_addr = 5'd6; s.wb_data = 32'hCAFE_0006;
      applyStimulus(s);

      // Stall for three cycles while ID changes, then flush wins over stall.
      for (int i = 0; i < 3; i++) begin
         s = randStim(); s.stall = 1; s.flush = 0;
         applyStimulus(s);
      end
      s = randStim(); s.valid = 1; s.rwe = 1; s.stall = 1; s.flush = 1;
      applyStimulus(s);

      // Load-use: lw x7 then add using x7, upstream re-presents the add.
      s = idleStim();
      s.valid = 1; s.pc = 32'h200; s.rs1 = 5'd3; s.rd = 5'd7; s.rwe = 1; s.mrd = 1;
      applyStimulus(s);
      s = idleStim();
      s.valid = 1; s.pc = 32'h204; s.rs1 = 5'd4; s.rs2 = 5'd7; s.rd = 5'd8; s.rwe = 1;
      applyStimulus(s);
      applyStimulus(s);
      applyStimulus(idleStim());

      // Randomized traffic.
      for (int i = 0; i < 300; i++) applyStimulus(randStim());

      // Reset mid-stream with a valid instruction held in EX.
      s = idleStim();
      s.valid = 1; s.pc = 32'h300; s.rs1 = 5'd3; s.rd = 5'd4; s.rwe = 1;
      applyStimulus(s);
      s.stall = 1;
      applyStimulus(s);
      pulseReset();
      s = idleStim();
      s.valid = 1; s.pc = 32'h400; s.rs1 = 5'd4; s.rs2 = 5'd5; s.rd = 5'd6; s.rwe = 1;
      applyStimulus(s);
      for (int i = 0; i < 20; i++) applyStimulus(randStim());

      @(posedge clock);
      #2;
      checkFlag("queue_drained", exp_q.size() == 0, 1'b1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
